// File: rtl/score_bar_renderer_if.sv
// score_bar_renderer_if: signals between the post-game score renderer and its
// neighbours. The inputs come from update_ram/datapath. The outputs are the
// pixel bus toward vga_adapter plus the busy/done status.
//
// Pixel bus semantics: plot is the valid strobe for x/y/colour. All four
// change together on the same clock edge. There is no ready: the adapter
// must accept one pixel on every cycle that plot is high. busy brackets a
// whole render. done is a single-cycle pulse that follows the last pixel.
interface score_bar_renderer_if;
    logic        running;
    logic [14:0] p1_count;
    logic [14:0] p2_count;
    logic [14:0] p3_count;
    logic [14:0] p4_count;
    logic [1:0]  winner;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  colour;
    logic        plot;
    logic        busy;
    logic        done;

    // Renderer side: consumes game status, drives the pixel bus.
    modport master (
        input  running, p1_count, p2_count, p3_count, p4_count, winner,
        output x, y, colour, plot, busy, done
    );

    // Environment side: supplies game status, observes the pixel bus.
    modport slave (
        output running, p1_count, p2_count, p3_count, p4_count, winner,
        input  x, y, colour, plot, busy, done
    );
endinterface

// File: rtl/score_bar_renderer.sv
// score_bar_renderer: when the game timer expires (running falls), this block
// snapshots the four territory counts. It then repaints a band of 4*BAR_H rows
// as one horizontal bar per player, writing one pixel per clock. Pixels past
// a bar's length are painted black, which erases stale territory underneath.
//
// Optional feature macro: SCORE_WINNER_MARK_EN. When it is defined, the
// right-most column (x=159) of the winner's rows is painted white.
module score_bar_renderer #(
    parameter int Y_TOP       = 100,
    parameter int BAR_H       = 3,
    parameter int SCALE_SHIFT = 7
) (
    input  logic                  CLOCK_50,
    input  logic                  resetn,
    score_bar_renderer_if.master  bus,
    output logic [1:0]            state_dbg
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LATCH  = 2'd1,
        DRAW   = 2'd2,
        FINISH = 2'd3
    } state_t;

    localparam logic [7:0] LAST_COL = 8'd159;
    localparam logic [7:0] MAX_LEN  = 8'd160;
    localparam logic [2:0] LAST_ROW = 3'(BAR_H - 1);

    state_t          state_q, state_d;
    logic            running_q;
    logic            fall;

    // Bar lengths are derived from the counts at snapshot time.
    // Nothing later in the render looks at the live counts.
    logic [3:0][7:0] len_q, len_d;

    // Scan position: bar (player), row within bar, column.
    logic [1:0]      bar_q, bar_d;
    logic [2:0]      row_q, row_d;
    logic [7:0]      col_q, col_d;
    logic            last_pixel;

    // Registered outputs.
    logic [7:0]      x_q, x_d;
    logic [6:0]      y_q, y_d;
    logic [2:0]      colour_q, colour_d;
    logic            plot_q, plot_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

`ifdef SCORE_WINNER_MARK_EN
    logic [1:0]      winner_q, winner_d;
`else
    logic            unused_winner;
    assign unused_winner = ^bus.winner;
`endif

    // Scaled bar length. Counts at or above 160<<SCALE_SHIFT saturate at a full row.
    function automatic logic [7:0] bar_len(input logic [14:0] cnt);
        logic [14:0] scaled;
        scaled = cnt >> SCALE_SHIFT;
        if (scaled > 15'(MAX_LEN)) begin
            return MAX_LEN;
        end
        return scaled[7:0];
    endfunction

    // Fixed colour assigned to each player.
    function automatic logic [2:0] player_colour(input logic [1:0] idx);
        case (idx)
            2'd0:    return 3'b001;
            2'd1:    return 3'b010;
            2'd2:    return 3'b100;
            default: return 3'b110;
        endcase
    endfunction

    assign fall       = running_q & ~bus.running;
    assign last_pixel = (bar_q == 2'd3) && (row_q == LAST_ROW) && (col_q == LAST_COL);

    // Edge detector history for running. It tracks the input in every state,
    // so a fall seen outside IDLE is consumed and never replayed later.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            running_q <= 1'b0;
        end else begin
            running_q <= bus.running;
        end
    end

    // FSM state register.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, scan counters, snapshot and next output values.
    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        bar_d    = bar_q;
        row_d    = row_q;
        col_d    = col_q;
        x_d      = x_q;
        y_d      = y_q;
        colour_d = colour_q;
        plot_d   = 1'b0;
        busy_d   = busy_q;
        done_d   = 1'b0;
`ifdef SCORE_WINNER_MARK_EN
        winner_d = winner_q;
`endif

        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (fall) begin
                    state_d = LATCH;
                end
            end

            LATCH: begin
                len_d[0] = bar_len(bus.p1_count);
                len_d[1] = bar_len(bus.p2_count);
                len_d[2] = bar_len(bus.p3_count);
                len_d[3] = bar_len(bus.p4_count);
`ifdef SCORE_WINNER_MARK_EN
                winner_d = bus.winner;
`endif
                bar_d   = 2'd0;
                row_d   = 3'd0;
                col_d   = 8'd0;
                busy_d  = 1'b1;
                state_d = DRAW;
            end

            DRAW: begin
                busy_d = 1'b1;
                plot_d = 1'b1;
                x_d    = col_q;
                // Row address stays inside 7 bits for any legal parameter set.
                y_d    = 7'(Y_TOP + int'(bar_q) * BAR_H + int'(row_q));
                colour_d = (col_q < len_q[bar_q]) ? player_colour(bar_q) : 3'b000;
`ifdef SCORE_WINNER_MARK_EN
                if ((bar_q == winner_q) && (col_q == LAST_COL)) begin
                    colour_d = 3'b111;
                end
`endif
                // Raster advance: column innermost, then row, then bar.
                if (col_q == LAST_COL) begin
                    col_d = 8'd0;
                    if (row_q == LAST_ROW) begin
                        row_d = 3'd0;
                        bar_d = bar_q + 2'd1;
                    end else begin
                        row_d = row_q + 3'd1;
                    end
                end else begin
                    col_d = col_q + 8'd1;
                end
                if (last_pixel) begin
                    state_d = FINISH;
                end
            end

            FINISH: begin
                // The last pixel is still on the bus during this cycle.
                // The registers drop plot and busy and raise done together.
                busy_d   = 1'b0;
                done_d   = 1'b1;
                colour_d = 3'b000;
                state_d  = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Datapath registers: snapshot, scan counters and outputs.
    // All of them clear immediately on reset.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            len_q    <= '0;
            bar_q    <= 2'd0;
            row_q    <= 3'd0;
            col_q    <= 8'd0;
            x_q      <= 8'd0;
            y_q      <= 7'd0;
            colour_q <= 3'd0;
            plot_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            len_q    <= len_d;
            bar_q    <= bar_d;
            row_q    <= row_d;
            col_q    <= col_d;
            x_q      <= x_d;
            y_q      <= y_d;
            colour_q <= colour_d;
            plot_q   <= plot_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

`ifdef SCORE_WINNER_MARK_EN
    // Winner snapshot, captured alongside the bar lengths.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            winner_q <= 2'd0;
        end else begin
            winner_q <= winner_d;
        end
    end
`endif

    assign bus.x      = x_q;
    assign bus.y      = y_q;
    assign bus.colour = colour_q;
    assign bus.plot   = plot_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign state_dbg  = state_q;

endmodule

// File: doc/score_bar_renderer.md
# score_bar_renderer

Post-game score display stage. It sits downstream of `update_ram`, consuming `p1_count`..`p4_count` and `winner`, and upstream of `vga_adapter`. When `running` falls (timer expiry), it snapshots the four territory counts. It then repaints a block of rows as four horizontal bars, one per player, with length proportional to that player's count, at one pixel per clock. While `busy`=1, the top level routes this block's `x`/`y`/`colour`/`plot` to the VGA adapter instead of `datapath`'s.

## Interface
Parameters:
- `Y_TOP`, 100: first row of bar area; requires `Y_TOP + 4*BAR_H - 1 <= 118`, since row 119 is the timer row.
- `BAR_H`, 3: rows per player bar (1..7).
- `SCALE_SHIFT`, 7: bar length = count >> SCALE_SHIFT, capped at 160.

Ports:
- `CLOCK_50`  in  1  system clock, 50 MHz; all state on its rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `running`  in  1  game-active level from `datapath`; a 1->0 transition starts rendering.
- `p1_count`, `p2_count`, `p3_count`, `p4_count`  in  15 each  cells owned per player.
- `winner`  in  2  winning player index (0 = p1 .. 3 = p4).
- `x`  out  8  pixel column.
- `y`  out  7  pixel row.
- `colour`  out  3  pixel colour.
- `plot`  out  1  pixel write strobe to `vga_adapter`.
- `busy`  out  1  high from LATCH through the final plot.
- `done`  out  1  one-cycle pulse after the final plot.

## Operation
- FSM states: IDLE, LATCH, DRAW, FINISH.
- `running_q` register; fall = `running_q & ~running`.
- IDLE:
  - On fall -> LATCH.
  - All other inputs are ignored.
- LATCH (1 cycle):
  - Snapshot all four counts and `winner`.
  - Compute len_i = min(count_i >> SCALE_SHIFT, 160), 8 bits.
  - Clear counters: bar i=0, row r=0, col c=0.
  - -> DRAW.
- DRAW (one pixel per cycle):
  - Drive x=c, y=Y_TOP + i*BAR_H + r, plot=1.
  - colour = player colour if c < len_i, else 3'b000 (clears stale territory).
  - Player colours: p1 3'b001, p2 3'b010, p3 3'b100, p4 3'b110.
  - Scan order: c 0..159 (inner), then r 0..BAR_H-1, then i 0..3.
  - After pixel (i=3, r=BAR_H-1, c=159) -> FINISH.
- FINISH (1 cycle): `done`=1, `busy`=0 -> IDLE.
- Boundaries:
  - len=0: row entirely black.
  - len=160, including any count >= 160<<SCALE_SHIFT: row entirely coloured.
  - c=len-1 is the last coloured pixel.
  - Count changes after LATCH do not affect output (snapshot).
  - Falls or rises of `running` while not in IDLE are ignored; no queued restart.
  - A fall in the same cycle as FINISH is ignored.
- Reset (asserted at any time, including mid-DRAW), immediate:
  - State -> IDLE.
  - x=0, y=0, colour=0, plot=0, busy=0, done=0.
  - `running_q`=0.
  - Snapshot registers cleared.
  - No `done` is produced for an aborted render.
  - `running` held 0 through reset release does not trigger a render.

## Timing
- Outputs are registered; no combinational path from inputs to outputs.
- Fall sampled at edge N (`running_q`=1, `running`=0):
  - LATCH occupies cycle N+1; `busy`=1 from edge N+1.
  - First plot (x=0, y=Y_TOP) is visible after edge N+2.
  - `plot` stays high for exactly 640*BAR_H consecutive cycles (1920 at default).
  - `done` is high for the single cycle after the last plot; `busy` falls on that same edge.
- Total latency from fall to `done`: 2 + 640*BAR_H + 1 cycles.
- Row address uses 7-bit arithmetic; parameter legality guarantees no wrap.

## Configuration
- `SCORE_WINNER_MARK_EN`:
  - Defined: during DRAW, every pixel at c=159 on the winner's BAR_H rows is plotted 3'b111, overriding the bar/black rule. All other pixels are unchanged.
  - Undefined: `winner` is unused (snapshot logic omitted) and c=159 follows the normal c < len rule.

## Test plan
- Default params; reset; `running` 1->0 with p1=1280 (len 10), p2=p3=p4=0:
  - Exactly 1920 plots.
  - y=100: x0..9 colour 001, x10..159 colour 000.
  - Rows 103..111 all 000.
  - `done` one cycle after the last plot.
- p2=32767, p3=127, p4=20480:
  - Rows 103..105 fully 010 (cap at 160).
  - Rows 106..108 fully 000 (len 0).
  - Rows 109..111 fully 110 (160 exactly).
- During DRAW, toggle `running` 0->1->0 and change all counts at pixel 300:
  - Still exactly 1920 plots.
  - Pixel colours match the LATCH-time snapshot.
  - Only one `done`.
- Assert `resetn` low at plot 500:
  - `plot`, `busy` and all outputs go to 0 immediately.
  - No `done`.
  - After release, with `running` held 0, no plot for 3000 cycles; a new 1->0 fall starts a full render.
- Fall-to-first-plot latency:
  - First plot visible exactly 2 edges after the fall is sampled.
  - `busy` high the cycle after the fall.
  - Total `busy` duration 1921 cycles.
- `SCORE_WINNER_MARK_EN` defined, winner=2, all counts 32767:
  - Rows 106..108 at x=159 are colour 111; all other pixels are normal.
  - Macro undefined, same stimulus: (159,106) is 100.
